// File: rtl/grf_bypass_sb_pkg.sv
// Shared constants for the general register file and its write scoreboard.
// Register-0 index, address/data widths, register count and counter width.
package grf_bypass_sb_pkg;

  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int REG_ZERO  = 0;
  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 2;

  // Registers that carry a scoreboard counter (all but $0).
  function automatic int nrsv(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/grf_sb_cnt.sv
// Saturating up/down in-flight write counter for one register.
// Ports: clk, rst, inc, dec -> cnt, zero, full, err (err = refused step).
module grf_sb_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full,
  output logic         err
);

  logic up;
  logic dn;

  // Simultaneous inc and dec cancel with no error.
  assign up   = inc && !dec;
  assign dn   = dec && !inc;
  assign zero = (cnt == '0);
  assign full = &cnt;
  assign err  = (up && full) || (dn && zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (up && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dn && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/grf_bypass_sb.sv
// Register file with W->D bypass and per-register pending-write scoreboard.
// Ports: Clk, Rst, We/A3/WD/PC (writeback), A1/A2 -> RD1/RD2/Busy1/Busy2,
// Rsv/RsvA -> RsvFull, SbErr. Macro GRF_DISPLAY_EN enables commit logging.
module grf_bypass_sb
  import grf_bypass_sb_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          We,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD,
  input  logic [DW-1:0] PC,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  input  logic          Rsv,
  input  logic [AW-1:0] RsvA,
  output logic          Busy1,
  output logic          Busy2,
  output logic          RsvFull,
  output logic          SbErr
);

  localparam logic [AW-1:0] R0 = AW'(REG_ZERO);

  logic [DW-1:0]    rf [NREG];
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  zero_v;
  logic [NREG-1:0]  full_v;
  logic [NREG-1:0]  err_v;
  logic             wr;
  logic             rel1;
  logic             rel2;
  logic             rsv_ok;

  assign wr     = We && (A3 != R0);
  assign rel1   = We && (A3 == A1);
  assign rel2   = We && (A3 == A2);
  assign rsv_ok = Rsv && (RsvA != R0);

  assign cnt[0]    = '0;
  assign zero_v[0] = 1'b1;
  assign full_v[0] = 1'b0;
  assign err_v[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_sb
    grf_sb_cnt #(.W(CNT_W)) u_cnt (
      .clk  (Clk),
      .rst  (Rst),
      .inc  (Rsv && (RsvA == AW'(i))),
      .dec  (We && (A3 == AW'(i))),
      .cnt  (cnt[i]),
      .zero (zero_v[i]),
      .full (full_v[i]),
      .err  (err_v[i])
    );
  end

  // Busy = (cnt - rel_hit) != 0: a release hitting a zero counter wraps
  // and therefore still reads busy.
  function automatic logic busy_f(
    input logic [AW-1:0]    a,
    input logic             z,
    input logic [CNT_W-1:0] c,
    input logic             rel
  );
    if (a == R0) return 1'b0;
    if (z) return rel;
    return !rel || (c != CNT_W'(1));
  endfunction

  assign Busy1 = busy_f(A1, zero_v[A1], cnt[A1], rel1);
  assign Busy2 = busy_f(A2, zero_v[A2], cnt[A2], rel2);

  assign RsvFull = rsv_ok && full_v[RsvA] && !(We && (A3 == RsvA));

  assign RD1 = (A1 == R0) ? '0 : rel1 ? WD : rf[A1];
  assign RD2 = (A2 == R0) ? '0 : rel2 ? WD : rf[A2];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr) begin
      rf[A3] <= WD;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      SbErr <= 1'b0;
    end else begin
      SbErr <= SbErr | (|err_v);
    end
  end

`ifdef GRF_DISPLAY_EN
  always_ff @(posedge Clk) begin
    if (!Rst && wr) begin
      $display("@%h: $%d <= %h", PC, A3, WD);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_grf_bypass_sb.sv
// Directed table-driven bench for grf_bypass_sb.
// One record per cycle: inputs driven at negedge, outputs checked before posedge.
module tb_grf_bypass_sb;

  logic        Clk = 1'b0;
  logic        Rst, We, Rsv;
  logic [4:0]  A3, A1, A2, RsvA;
  logic [31:0] WD, PC, RD1, RD2;
  logic        Busy1, Busy2, RsvFull, SbErr;

  grf_bypass_sb dut (
    .Clk(Clk), .Rst(Rst), .We(We), .A3(A3), .WD(WD), .PC(PC),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .Rsv(Rsv), .RsvA(RsvA),
    .Busy1(Busy1), .Busy2(Busy2), .RsvFull(RsvFull), .SbErr(SbErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, we;
    logic [4:0]  a3;
    logic [31:0] wd, pc;
    logic [4:0]  a1, a2;
    logic        rsv;
    logic [4:0]  rsva;
    logic        chk;
    logic [31:0] rd1, rd2;
    logic        b1, b2, full, err;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   passed = 0;
  bit   done = 1'b0;

  function automatic vec_t mk(
    input logic rst, we, input logic [4:0] a3, input logic [31:0] wd,
    input logic [4:0] a1, a2, input logic rsv, input logic [4:0] rsva,
    input logic chk, input logic [31:0] rd1, rd2,
    input logic b1, b2, full, err
  );
    vec_t v;
    v.rst = rst; v.we = we; v.a3 = a3; v.wd = wd; v.pc = 32'h3000;
    v.a1 = a1; v.a2 = a2; v.rsv = rsv; v.rsva = rsva; v.chk = chk;
    v.rd1 = rd1; v.rd2 = rd2; v.b1 = b1; v.b2 = b2;
    v.full = full; v.err = err;
    return v;
  endfunction

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: run did not finish");
      $finish;
    end
  end

  initial begin
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,5,0,0,0, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,8,0,1,8, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,8,0,0,0, 1,0,0,1,0,0,0));
    vq.push_back(mk(0,1,8,32'h12345678,8,0,0,0,
                    1,32'h12345678,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,8,0,0,0, 1,32'h12345678,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,9,1,9, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,9,1,9, 1,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,9,1,9, 1,0,0,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,9,1,9, 1,0,0,0,1,1,0));
    vq.push_back(mk(0,0,0,0,0,9,0,0, 1,0,0,0,1,0,1));
    vq.push_back(mk(0,1,9,32'h99,0,9,0,0, 1,0,32'h99,0,1,0,1));
    vq.push_back(mk(0,1,9,32'h9a,0,9,0,0, 1,0,32'h9a,0,1,0,1));
    vq.push_back(mk(0,1,9,32'h9b,0,9,0,0, 1,0,32'h9b,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,9,0,0, 1,0,32'h9b,0,0,0,1));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,8,9,0,0, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,10,0,1,10, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,1,10,32'haa,10,0,1,10, 1,32'haa,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,10,0,0,0, 1,32'haa,0,1,0,0,0));
    vq.push_back(mk(0,1,10,32'hbb,10,0,0,0, 1,32'hbb,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,10,0,0,0, 1,32'hbb,0,0,0,0,0));
    vq.push_back(mk(0,1,10,32'hcc,11,0,1,10, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,10,0,0,0, 1,32'hcc,0,0,0,0,0));
    vq.push_back(mk(0,1,0,32'hffffffff,0,0,1,0, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,3,0,1,3, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,3,0,0,0, 1,0,0,1,0,0,0));
    vq.push_back(mk(1,0,0,0,3,0,0,0, 0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,3,0,0,0, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,1,3,32'h1,0,0,0,0, 1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,3,0,0,0, 1,32'h1,0,0,0,0,1));
    vq.push_back(mk(0,1,5,32'h55,4,0,1,4, 1,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,4,5,0,0, 1,0,32'h55,1,0,0,1));

    Rst = 1'b1; We = 1'b0; A3 = '0; WD = '0; PC = '0;
    A1 = '0; A2 = '0; Rsv = 1'b0; RsvA = '0;

    foreach (vq[k]) begin
      @(negedge Clk);
      Rst = vq[k].rst; We = vq[k].we; A3 = vq[k].a3; WD = vq[k].wd;
      PC = vq[k].pc; A1 = vq[k].a1; A2 = vq[k].a2;
      Rsv = vq[k].rsv; RsvA = vq[k].rsva;
      #1;
      if (vq[k].chk) begin
        total++;
        if (RD1 === vq[k].rd1 && RD2 === vq[k].rd2 &&
            Busy1 === vq[k].b1 && Busy2 === vq[k].b2 &&
            RsvFull === vq[k].full && SbErr === vq[k].err) begin
          passed++;
        end else begin
          $display("FAIL row%0d got rd1=%h rd2=%h b1=%b b2=%b full=%b err=%b want rd1=%h rd2=%h b1=%b b2=%b full=%b err=%b",
                   k, RD1, RD2, Busy1, Busy2, RsvFull, SbErr,
                   vq[k].rd1, vq[k].rd2, vq[k].b1, vq[k].b2,
                   vq[k].full, vq[k].err);
        end
      end
    end

    @(negedge Clk);
    Rst = 1'b1; We = 1'b0; Rsv = 1'b0;
    A1 = 5'd5; A2 = 5'd0;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    total++;
    if (RD1 === '0 && RD2 === '0 && Busy1 === 1'b0 &&
        Busy2 === 1'b0 && RsvFull === 1'b0 && SbErr === 1'b0) begin
      passed++;
    end else begin
      $display("FAIL reset state rd1=%h rd2=%h b1=%b b2=%b full=%b err=%b",
               RD1, RD2, Busy1, Busy2, RsvFull, SbErr);
    end

    @(negedge Clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
